// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder slice.
package dmem_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_e;

endpackage

// File: rtl/dmem_lane_fmt.sv
// RV32I byte-lane steering: store enables/data, load extraction, access legality.
// Misaligned halfword/word accesses trap only when MISALIGN_TRAP_EN is defined.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        write_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [31:0] rshift;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic        illegal;
  logic        misal;
  logic [3:0]  be;
  logic [31:0] rd;

  always_comb begin
    rshift  = rword_i >> {addr_lo_i, 3'b000};
    rbyte   = rshift[7:0];
    rhalf   = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    illegal = 1'b0;
    be      = '0;
    rd      = '0;
    wdata_o = wdata_i;
    case (funct3_i)
      F3_B: begin
        be      = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rd      = {{24{rbyte[7]}}, rbyte};
      end
      F3_H: begin
        be      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rd      = {{16{rhalf[15]}}, rhalf};
      end
      F3_W: begin
        be = '1;
        rd = rword_i;
      end
      F3_BU: begin
        illegal = write_i;
        rd      = {24'd0, rbyte};
      end
      F3_HU: begin
        illegal = write_i;
        rd      = {16'd0, rhalf};
      end
      default: illegal = 1'b1;
    endcase

`ifdef MISALIGN_TRAP_EN
    misal = (((funct3_i == F3_H) || (funct3_i == F3_HU)) && addr_lo_i[0]) ||
            ((funct3_i == F3_W) && (addr_lo_i != 2'b00));
`else
    misal = 1'b0;
`endif

    err_o   = illegal | misal;
    be_o    = (write_i && !err_o) ? be : 4'b0000;
    rdata_o = (write_i || err_o) ? 32'd0 : rd;
  end

endmodule

// File: rtl/dmem_responder.sv
// Slow data-memory responder: one outstanding request, WAIT_CYCLES of delay,
// held response. Build option: MISALIGN_TRAP_EN (see dmem_lane_fmt).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DEPTH_LOG2+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  write_q;
  logic [2:0]            funct3_q;
  logic                  resp_valid_q;
  logic [31:0]           resp_rdata_q;
  logic                  resp_err_q;

  logic [31:0] mem_q [DEPTH];

  logic [31:0] rword;
  logic [3:0]  be;
  logic [31:0] wdata_sh;
  logic [31:0] fmt_rdata;
  logic        fmt_err;
  logic        access;
  logic        unused_addr_hi;

  // Upper address bits alias onto the array by design.
  assign unused_addr_hi = ^req_addr[31:DEPTH_LOG2+2];

  assign rword  = mem_q[addr_q[DEPTH_LOG2+1:2]];
  assign access = (state_q == S_BUSY) && (cnt_q == '0);

  dmem_lane_fmt u_lane_fmt (
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_q[1:0]),
    .write_i   (write_q),
    .wdata_i   (wdata_q),
    .rword_i   (rword),
    .be_o      (be),
    .wdata_o   (wdata_sh),
    .rdata_o   (fmt_rdata),
    .err_o     (fmt_err)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr[DEPTH_LOG2+1:0];
            wdata_q  <= req_wdata;
            write_q  <= req_write;
            funct3_q <= req_funct3;
            cnt_q    <= CNT_W'(WAIT_CYCLES);
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= fmt_rdata;
            resp_err_q   <= fmt_err;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Array is never reset; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && access) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr_q[DEPTH_LOG2+1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign req_ready  = rst && (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected
// responses; a monitor pops and compares on each response handshake.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned W1 = 1;
  localparam int unsigned W3 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, req_write, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;

  logic        rr1, rv1, re1, rr3, rv3, re3;
  logic [31:0] rd1, rd3;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(W1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && !sel), .req_ready(rr1),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_write(req_write), .req_funct3(req_funct3),
    .resp_valid(rv1), .resp_ready(resp_ready),
    .resp_rdata(rd1), .resp_err(re1)
  );

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(W3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && sel), .req_ready(rr3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_write(req_write), .req_funct3(req_funct3),
    .resp_valid(rv3), .resp_ready(resp_ready),
    .resp_rdata(rd3), .resp_err(re3)
  );

  assign req_ready  = sel ? rr3 : rr1;
  assign resp_valid = sel ? rv3 : rv1;
  assign resp_rdata = sel ? rd3 : rd1;
  assign resp_err   = sel ? re3 : re1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned n_vec = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  logic        prev_rv = 1'b0;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && resp_valid && !prev_rv)
      check("latency", cyc - acc_cyc, (sel ? W3 : W1) + 1);
    if (rst === 1'b1 && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_resp: got rdata %h err %b expected no response", resp_rdata, resp_err);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, ".rdata"}, resp_rdata, mon_e.rdata);
        check({mon_e.name, ".err"}, {31'd0, resp_err}, {31'd0, mon_e.err});
      end
    end
    prev_rv = resp_valid;
  end

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input string nm);
    int unsigned t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s.accept: got req_ready 0 expected 1 within 50 cycles", nm);
      return;
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    sb.push_back('{exp_rd, exp_err, nm});
  endtask

  task automatic drain();
    int unsigned t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: got %0d pending responses expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic xact(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd,
                      input logic exp_err, input string nm);
    issue(wr, f3, a, wd, exp_rd, exp_err, nm);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t;
    rst = 1'b0; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    resp_ready = 1'b1; req_addr = '0; req_wdata = '0; req_funct3 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.req_ready", {31'd0, rr1}, 32'd0);
    check("rst.resp_valid", {31'd0, rv1}, 32'd0);
    check("rst.resp_rdata", rd1, 32'd0);
    check("rst.resp_err", {31'd0, re1}, 32'd0);
    check("rst.req_ready3", {31'd0, rr3}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle.req_ready", {31'd0, req_ready}, 32'd1);

    // 1: word store/load
    xact(1'b1, F3_W, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, "sw_100");
    xact(1'b0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, "lw_100");

    // 2: byte store and loads
    xact(1'b1, F3_B, 32'h103, 32'h00000080, 32'h0, 1'b0, "sb_103");
    xact(1'b0, F3_B, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, "lb_103");
    xact(1'b0, F3_BU, 32'h103, 32'h0, 32'h00000080, 1'b0, "lbu_103");
    xact(1'b0, F3_W, 32'h100, 32'h0, 32'h80ADBEEF, 1'b0, "lw_100b");

    // 3: halves and illegal funct3
    xact(1'b0, F3_H, 32'h102, 32'h0, 32'hFFFF80AD, 1'b0, "lh_102");
    xact(1'b0, F3_HU, 32'h102, 32'h0, 32'h000080AD, 1'b0, "lhu_102");
    xact(1'b1, 3'b011, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1, "st_f3_011");
    xact(1'b1, F3_BU, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1, "st_f3_100");
    xact(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 1'b1, "ld_f3_110");
    xact(1'b0, F3_W, 32'h100, 32'h0, 32'h80ADBEEF, 1'b0, "lw_100c");

    // 4: response backpressure with a stray request
    resp_ready = 1'b0;
    issue(1'b0, F3_W, 32'h100, 32'h0, 32'h80ADBEEF, 1'b0, "lw_bp");
    t = 0;
    while (!resp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      req_valid  = (i % 2 == 0);
      req_write  = 1'b1;
      req_funct3 = F3_W;
      req_addr   = 32'h100;
      req_wdata  = 32'h0BAD0BAD;
      @(negedge clk);
      check("bp.resp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp.resp_rdata", resp_rdata, 32'h80ADBEEF);
      check("bp.req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    drain();
    @(negedge clk);
    check("bp.ready_after", {31'd0, req_ready}, 32'd1);
    xact(1'b0, F3_W, 32'h100, 32'h0, 32'h80ADBEEF, 1'b0, "lw_after_bp");

    // 5: misaligned accesses
    if (TRAP) begin
      xact(1'b0, F3_W, 32'h101, 32'h0, 32'h0, 1'b1, "lw_101");
      xact(1'b1, F3_H, 32'h101, 32'h0000AAAA, 32'h0, 1'b1, "sh_101");
      xact(1'b0, F3_W, 32'h100, 32'h0, 32'h80ADBEEF, 1'b0, "lw_100d");
      xact(1'b0, F3_B, 32'h101, 32'h0, 32'hFFFFFFBE, 1'b0, "lb_101");
    end else begin
      xact(1'b0, F3_W, 32'h101, 32'h0, 32'h80ADBEEF, 1'b0, "lw_101");
      xact(1'b1, F3_H, 32'h101, 32'h0000AAAA, 32'h0, 1'b0, "sh_101");
      xact(1'b0, F3_W, 32'h100, 32'h0, 32'h80ADAAAA, 1'b0, "lw_100d");
      xact(1'b0, F3_B, 32'h101, 32'h0, 32'hFFFFFFAA, 1'b0, "lb_101");
    end

    // 6a: reset drops a pending store (WAIT_CYCLES=3 instance)
    @(negedge clk);
    sel = 1'b1;
    xact(1'b1, F3_W, 32'h200, 32'h11111111, 32'h0, 1'b0, "sw_200_pre");
    issue(1'b1, F3_W, 32'h200, 32'h12345678, 32'h0, 1'b0, "sw_200_drop");
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid.resp_valid", {31'd0, resp_valid}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_mid.no_resp", {31'd0, resp_valid}, 32'd0);
    end
    xact(1'b0, F3_W, 32'h200, 32'h0, 32'h11111111, 1'b0, "lw_200");

    // 6b: address wrap-around on the DEPTH_LOG2=10 instance
    @(negedge clk);
    sel = 1'b0;
    xact(1'b1, F3_W, 32'h1100, 32'hCAFEF00D, 32'h0, 1'b0, "sw_1100");
    xact(1'b0, F3_W, 32'h100, 32'h0, 32'hCAFEF00D, 1'b0, "lw_wrap");
    xact(1'b0, F3_HU, 32'h102, 32'h0, 32'h0000CAFE, 1'b0, "lhu_wrap");
    xact(1'b0, F3_B, 32'h100, 32'h0, 32'h0000000D, 1'b0, "lb_wrap");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
